// File: rtl/mem_pkg.sv
// Shared definitions for the memory request controller.
//   MEM_ADDR_W / MEM_DATA_W : default memory address and data widths
//   TXN_CNT_W               : width of the completed-transaction counter
//   mem_state_e             : controller FSM state encoding
package mem_pkg;

  localparam int unsigned MEM_ADDR_W = 4;
  localparam int unsigned MEM_DATA_W = 8;
  localparam int unsigned TXN_CNT_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_RCAP  = 3'd3,
    ST_RESP  = 3'd4
  } mem_state_e;

endpackage

// File: rtl/mem_req_ctrl.sv
// Single-outstanding memory request controller.
// Accepts one read or write request at a time from an upstream valid/ready
// port, drives a simple synchronous memory port, and returns read data on a
// downstream valid/ready port.
//   clk, rst                       : clock, synchronous active-high reset
//   req_valid/req_ready            : request handshake (ready only in IDLE)
//   req_we, req_addr, req_wdata    : request type, address, write data
//   rsp_valid/rsp_ready, rsp_data  : read response handshake and data
//   r_w, addr, wr_d                : memory control (1 = write), address, data
//   rd_d                           : memory read data, one cycle after address
//   txn_cnt                        : wrapping count of completed transactions
module mem_req_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DATA_W = MEM_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_data,
  output logic                 r_w,
  output logic [ADDR_W-1:0]    addr,
  output logic [DATA_W-1:0]    wr_d,
  input  logic [DATA_W-1:0]    rd_d,
  output logic [TXN_CNT_W-1:0] txn_cnt
);

  mem_state_e             state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [DATA_W-1:0]      rsp_data_q, rsp_data_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   r_w_q, r_w_d;
  logic [TXN_CNT_W-1:0]   txn_cnt_q, txn_cnt_d;

  // Next-state and datapath updates
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    txn_cnt_d  = txn_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = req_we ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        state_d   = ST_IDLE;
        txn_cnt_d = txn_cnt_q + TXN_CNT_W'(1);
      end
      ST_READ: begin
        state_d = ST_RCAP;
      end
      // rd_d is valid here, one cycle after the address was presented
      ST_RCAP: begin
        rsp_data_d = rd_d;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d   = ST_IDLE;
          txn_cnt_d = txn_cnt_q + TXN_CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered decodes of the upcoming state
    r_w_d       = (state_d == ST_WRITE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      r_w_q       <= 1'b0;
      txn_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      r_w_q       <= r_w_d;
      txn_cnt_q   <= txn_cnt_d;
    end
  end

  // Ready is combinational so a request can be taken in the first IDLE cycle
  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign r_w       = r_w_q;
  assign addr      = addr_q;
  assign wr_d      = wdata_q;
  assign txn_cnt   = txn_cnt_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Self-checking bench for mem_req_ctrl with a behavioural memory device and a
// transaction-level reference model (memory image, expected count, read queue).
module tb_mem_req_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic        r_w;
  logic [3:0]  addr;
  logic [7:0]  wr_d;
  logic [7:0]  rd_d;
  logic [15:0] txn_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [7:0]  ref_mem [16];
  logic [15:0] exp_cnt;

  // Memory device attached to the controller's memory port
  logic [7:0]  mem_arr [16];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (r_w) mem_arr[addr] <= wr_d;
    rd_d <= mem_arr[addr];
  end

  mem_req_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .r_w       (r_w),
    .addr      (addr),
    .wr_d      (wr_d),
    .rd_d      (rd_d),
    .txn_cnt   (txn_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_ready"},     32'(req_ready), 0);
    check({pfx, "_rsp_valid"}, 32'(rsp_valid), 0);
    check({pfx, "_rsp_data"},  32'(rsp_data),  0);
    check({pfx, "_rw"},        32'(r_w),       0);
    check({pfx, "_addr"},      32'(addr),      0);
    check({pfx, "_wr_d"},      32'(wr_d),      0);
    check({pfx, "_cnt"},       32'(txn_cnt),   0);
  endtask

  // Waits (bounded) at falling edges until the controller is ready
  task automatic wait_ready();
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    if (!req_ready) check("req_ready_timeout", 32'(req_ready), 1);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    wait_ready();
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = 4'($urandom); req_wdata = 8'($urandom);
    check("wr_rw",        32'(r_w),       1);
    check("wr_addr",      32'(addr),      32'(a));
    check("wr_data",      32'(wr_d),      32'(d));
    check("wr_rsp_valid", 32'(rsp_valid), 0);
    check("wr_busy",      32'(req_ready), 0);
    ref_mem[a] = d;
    exp_cnt++;
    @(negedge clk);
    check("wr_rw_done",   32'(r_w),       0);
    check("wr_cnt",       32'(txn_cnt),   32'(exp_cnt));
    check("wr_ready",     32'(req_ready), 1);
    check("wr_addr_hold", 32'(addr),      32'(a));
  endtask

  task automatic do_read(input logic [3:0] a, input int hold);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = 8'($urandom);
    wait_ready();
    @(negedge clk);
    req_valid = 1'b0;
    check("rd_rw",     32'(r_w),       0);
    check("rd_addr",   32'(addr),      32'(a));
    check("rd_early1", 32'(rsp_valid), 0);
    rsp_ready = 1'($urandom);
    @(negedge clk);
    check("rd_early2", 32'(rsp_valid), 0);
    check("rd_rw2",    32'(r_w),       0);
    rsp_ready = 1'($urandom);
    @(negedge clk);
    check("rd_rsp_valid", 32'(rsp_valid), 1);
    check("rd_data",      32'(rsp_data),  32'(ref_mem[a]));
    for (int k = 0; k < hold; k++) begin
      rsp_ready = 1'b0;
      @(negedge clk);
      check("rd_hold_valid", 32'(rsp_valid), 1);
      check("rd_hold_data",  32'(rsp_data),  32'(ref_mem[a]));
      check("rd_hold_busy",  32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_cnt++;
    check("rd_done_valid", 32'(rsp_valid), 0);
    check("rd_cnt",        32'(txn_cnt),   32'(exp_cnt));
    check("rd_ready",      32'(req_ready), 1);
  endtask

  // Starts a read and asserts reset once the given number of cycles have elapsed
  // after the handshake (1 = READ, 2 = RCAP, 3 = RESP).
  task automatic read_abort(input logic [3:0] a, input int phase);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    wait_ready();
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    for (int k = 1; k < phase; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state($sformatf("abort%0d", phase));
    rst = 1'b0;
    #1;
    check("abort_ready_after", 32'(req_ready), 1);
    exp_cnt = '0;
  endtask

  task automatic stream_test();
    logic [3:0] s_a [16];
    logic [7:0] s_d [16];
    bit         s_we [16];
    logic [7:0] q [$];
    int         acc;
    bit         pend;
    for (int i = 0; i < 16; i++) begin
      s_we[i] = (i % 2 == 0);
      s_d[i]  = 8'($urandom);
      s_a[i]  = s_we[i] ? 4'($urandom) : s_a[i-1];
    end
    acc = 0;
    pend = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = s_we[0]; req_addr = s_a[0]; req_wdata = s_d[0];
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (pend) begin
        check("st_rw",   32'(r_w),  32'(s_we[acc]));
        check("st_addr", 32'(addr), 32'(s_a[acc]));
        acc++;
        pend = 1'b0;
        if (acc < 16) begin
          req_we = s_we[acc]; req_addr = s_a[acc]; req_wdata = s_d[acc];
        end else begin
          req_valid = 1'b0;
        end
      end
      if (rsp_valid) begin
        if (q.size() == 0) check("st_spurious_rsp", 32'(rsp_valid), 0);
        else check("st_rdata", 32'(rsp_data), 32'(q.pop_front()));
      end
      if (req_valid && req_ready) begin
        check("st_accept_idle", 32'({rsp_valid, r_w}), 0);
        if (s_we[acc]) ref_mem[s_a[acc]] = s_d[acc];
        else q.push_back(ref_mem[s_a[acc]]);
        exp_cnt++;
        pend = 1'b1;
      end
      if (acc == 16 && !pend && !rsp_valid && q.size() == 0) break;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check("st_accepted", 32'(acc),      16);
    check("st_queue",    32'(q.size()), 0);
    check("st_cnt",      32'(txn_cnt),  32'(exp_cnt));
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0;
    exp_cnt = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    #1;
    check("ready_after_reset", 32'(req_ready), 1);

    // Fill memory so every later read has a known value
    for (int a = 0; a < 16; a++) do_write(4'(a), 8'($urandom));

    do_write(4'd3, 8'hA5);
    do_write(4'd7, 8'h5A);
    do_read(4'd7, 0);
    check("read_7_value", 32'(rsp_data), 32'h5A);
    do_read(4'($urandom), 5);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) do_write(4'($urandom), 8'($urandom));
      else do_read(4'($urandom), int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    stream_test();

    read_abort(4'($urandom), 1);
    read_abort(4'($urandom), 2);
    read_abort(4'($urandom), 3);
    do_read(4'($urandom), 1);
    do_write(4'($urandom), 8'($urandom));

    // Counter wrap: preload near the top instead of issuing 65535 writes
    @(negedge clk);
    force dut.txn_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.txn_cnt_q;
    exp_cnt = 16'hFFFE;
    do_write(4'($urandom), 8'($urandom));
    check("cnt_top", 32'(txn_cnt), 32'hFFFF);
    do_write(4'($urandom), 8'($urandom));
    check("cnt_wrap", 32'(txn_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
